// File: rtl/rgb_pkg.sv
// Shared constants and helpers for the RGB/RGBW LED serial pipeline.
package rgb_pkg;

  localparam int unsigned WORD_BITS_RGB     = 24;
  localparam int unsigned WORD_BITS_RGBW    = 32;
  localparam int unsigned STREAM_RESET_CLKS = 4800;
  localparam int unsigned SAMPLE_TIME_CLKS  = 57;

  // Width of one index-tagged FIFO entry: {index, word}.
  function automatic int unsigned fifo_entry_width(input int unsigned word_bits,
                                                   input int unsigned idx_bits);
    return word_bits + idx_bits;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous show-ahead FIFO. A write while full is accepted only when a read
// happens in the same cycle. rd_data reads as zero while the FIFO is empty.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_rd;
  logic             w_wr;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_comb begin
    empty   = (r_wr_ptr == r_rd_ptr);
    full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_rd    = rd_en & ~empty;
    w_wr    = wr_en & (~full | w_rd);
    rd_data = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  end

  // Storage array; no reset needed since the head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

  // Read/write pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/rgbx_sbit2wrd_fifo.sv
// Assembles strobed serial bits MSB-first into LED words, tags each with its
// LED index within the frame and queues them in a show-ahead FIFO.
module rgbx_sbit2wrd_fifo
  import rgb_pkg::*;
#(
  parameter int unsigned WORD_BITS  = WORD_BITS_RGB,
  parameter int unsigned IDX_BITS   = 8,
  parameter int unsigned MAX_LEDS   = 256,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 strobe,
  input  logic                 sbit_value,
  input  logic                 stream_reset,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_BITS-1:0] out_word,
  output logic [IDX_BITS-1:0]  out_index,
  output logic                 frame_start,
  output logic                 partial_err,
  output logic                 led_ovf,
  output logic                 fifo_ovr
);

  localparam int unsigned CNT_W   = $clog2(WORD_BITS) + 1;
  localparam int unsigned ENTRY_W = fifo_entry_width(WORD_BITS, IDX_BITS);
  localparam logic [CNT_W-1:0]  LastBit = CNT_W'(WORD_BITS - 1);
  localparam logic [IDX_BITS:0] MaxIdx  = (IDX_BITS + 1)'(MAX_LEDS);

  logic                 r_strobe_q;
  logic [WORD_BITS-2:0] r_shift;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [IDX_BITS:0]    r_idx;
  logic                 r_frame_start;
  logic                 r_partial_err;
  logic                 r_led_ovf;
  logic                 r_fifo_ovr;

  logic                 w_event;
  logic                 w_data_evt;
  logic                 w_sr_evt;
  logic                 w_word_done;
  logic [WORD_BITS-1:0] w_word;
  logic                 w_idx_ok;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_push;
  logic [ENTRY_W-1:0]   w_wr_data;
  logic [ENTRY_W-1:0]   w_rd_data;

  // Rising-edge event detect and word-completion decode.
  always_comb begin
    w_event     = strobe & ~r_strobe_q;
    w_data_evt  = w_event & ~stream_reset;
    w_sr_evt    = w_event & stream_reset;
    w_word      = {r_shift, sbit_value};
    w_word_done = w_data_evt && (r_bit_cnt == LastBit);
    w_idx_ok    = (r_idx < MaxIdx);
    w_pop       = ~w_empty & out_ready;
    // A full FIFO still takes the word when the head leaves in the same cycle.
    w_push      = w_word_done & w_idx_ok & (~w_full | w_pop);
    w_wr_data   = {r_idx[IDX_BITS-1:0], w_word};
  end

  // Assembler state: shift register, bit counter, LED index and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_strobe_q    <= 1'b0;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_idx         <= '0;
      r_frame_start <= 1'b0;
      r_partial_err <= 1'b0;
      r_led_ovf     <= 1'b0;
      r_fifo_ovr    <= 1'b0;
    end else begin
      r_strobe_q    <= strobe;
      r_frame_start <= w_sr_evt;
      r_partial_err <= w_sr_evt && (r_bit_cnt != '0);
      if (w_sr_evt) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
        r_idx     <= '0;
        r_led_ovf <= 1'b0;
      end else if (w_data_evt) begin
        r_shift <= w_word[WORD_BITS-2:0];
        if (w_word_done) begin
          r_bit_cnt <= '0;
          if (w_idx_ok) begin
            r_idx <= r_idx + (IDX_BITS + 1)'(1);
            if (w_full && !w_pop) r_fifo_ovr <= 1'b1;
          end else begin
            r_led_ovf <= 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_push),
    .wr_data (w_wr_data),
    .full    (w_full),
    .rd_en   (out_ready),
    .rd_data (w_rd_data),
    .empty   (w_empty)
  );

  // Output mapping from the FIFO head and flag registers.
  always_comb begin
    out_valid   = ~w_empty;
    out_word    = w_rd_data[WORD_BITS-1:0];
    out_index   = w_rd_data[ENTRY_W-1 -: IDX_BITS];
    frame_start = r_frame_start;
    partial_err = r_partial_err;
    led_ovf     = r_led_ovf;
    fifo_ovr    = r_fifo_ovr;
  end

endmodule

// File: doc/rgbx_sbit2wrd_fifo.md
Name: rgbx_sbit2wrd_fifo

Overview:
Parametrised successor to the RGB serial-bit-to-word assembler. It takes strobed serial bits (or stream-reset events) from the serial input decoder and assembles them MSB-first into WORD_BITS-wide LED words: 24 for RGB, 32 for RGBW. Each completed word is tagged with its LED index within the frame and buffered in a small FIFO with a valid/ready handshake toward the RGB-to-RGBW conversion stage. Error flags report partial words, LED-count overflow and FIFO overrun.

Parameters:
WORD_BITS, 24, bits per LED word (24 or 32; any value 8..32 legal)
IDX_BITS, 8, width of LED index within a frame
MAX_LEDS, 256, words accepted per frame; must be <= 2**IDX_BITS
FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
strobe  in  1  bit event from decoder; may stay high for multiple clocks
sbit_value  in  1  bit value, sampled on the strobe event
stream_reset  in  1  when 1 on the strobe event, marks end of frame (50 us idle)
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head when out_valid & out_ready
out_word  out  WORD_BITS  head word; bit WORD_BITS-1 = first received bit
out_index  out  IDX_BITS  LED index of head word (0 = first after stream reset)
frame_start  out  1  one-cycle pulse on a stream-reset event
partial_err  out  1  one-cycle pulse: stream reset arrived with 1..WORD_BITS-1 bits pending
led_ovf  out  1  sticky: a word arrived with index >= MAX_LEDS; cleared by stream reset
fifo_ovr  out  1  sticky: a word was dropped because the FIFO was full; cleared only by rst

Behaviour:
- Reset (async, rst=1): shift register, bit_cnt, idx, strobe_q and FIFO pointers are 0. All outputs are 0, including out_word and out_index.
- Event detect: strobe_q registers strobe. event = strobe & ~strobe_q. A strobe held high for N clocks produces exactly one event. A strobe high out of reset counts as an event on its first sampled cycle.
- Data event (stream_reset=0): shift = {shift[WORD_BITS-2:0], sbit_value}; bit_cnt increments.
- Word completion: on the event where bit_cnt == WORD_BITS-1 at the same edge:
  - bit_cnt returns to 0.
  - If idx < MAX_LEDS and the FIFO is not full, {idx, completed word} is written.
  - idx increments and saturates at MAX_LEDS.
  - If idx >= MAX_LEDS: the word is dropped and led_ovf is set.
  - Else if the FIFO is full: the word is dropped, fifo_ovr is set, and idx still increments.
- Latency: a completed word is written at the event edge. out_valid is high from the next cycle when the FIFO was empty, so it is visible 1 clk after the completing strobe is sampled.
- Stream-reset event (stream_reset=1; sbit_value ignored):
  - bit_cnt, shift and idx are set to 0 and led_ovf is cleared.
  - frame_start pulses for 1 clk.
  - partial_err pulses for 1 clk if bit_cnt != 0.
  - FIFO contents are NOT flushed.
- FIFO: show-ahead; out_word and out_index reflect the head whenever out_valid=1. A pop occurs when out_valid & out_ready. A simultaneous push and pop on a full FIFO is accepted: pop first, no overrun. The FIFO is empty after a pop of the last entry with no push.
- No state machine beyond bit_cnt and idx. The states are implicit: IDLE_FRAME (idx=0, bit_cnt=0), ASSEMBLING and SATURATED (idx=MAX_LEDS).
- Widths: bit_cnt is $clog2(WORD_BITS)+1 bits. idx is IDX_BITS+1 bits internally so saturation is representable. out_index carries the low IDX_BITS.
- Reset asserted mid-word or mid-frame discards everything immediately, including FIFO contents.

Decomposition:
- Shared package rgb_pkg holds:
  - localparams WORD_BITS_RGB=24 and WORD_BITS_RGBW=32.
  - STREAM_RESET_CLKS=4800 and SAMPLE_TIME_CLKS=57, shared with the decoder and testbenches.
  - A function for index-tagged FIFO entry width (WORD_BITS+IDX_BITS).
- One sub-module is natural: sync_fifo_fwft (parameters WIDTH, DEPTH; ports clk, rst, wr_en, wr_data, full, rd_en, rd_data, empty). The assembler logic stays in the top module.

Test Plan:
1. Out of reset, WORD_BITS=24: send stream reset, then 24 events of alternating 1,0 starting with 1 -> frame_start pulse; out_valid=1 one clk after the 24th event; out_word=24'hAAAAAA, out_index=0.
2. Strobe widths of 1, 2, 3 and 4 clocks carrying bits 0,1,0,1, then 20 more 1s -> exactly 24 bits captured; out_word=24'h5FFFFF; no extra words.
3. WORD_BITS=32, out_ready=0: send 5 words of 32'h01020304 -> 4 words buffered; fifo_ovr=1 after the 5th; draining yields indices 0,1,2,3.
4. Send 10 bits, then stream reset -> partial_err pulses for 1 clk; no word emitted; next word gets out_index=0.
5. MAX_LEDS=2: send 3 words -> indices 0 and 1 are output; led_ovf=1 after the 3rd; stream reset clears led_ovf.
6. Assert rst for 1 clk after 12 bits with 2 words queued -> out_valid=0 immediately; the next 24 bits form a fresh word with index 0.
